// File: rtl/ins_decode_pkg.sv
// Shared encodings and the ID/EX record for the registered decode stage.
package ins_decode_pkg;

  localparam int ID_DATA_W = 32;

  // Primary opcodes (ins[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  // R-type function codes (ins[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operation codes seen by EX
  localparam logic [7:0] ALU_AND  = 8'h24;
  localparam logic [7:0] ALU_OR   = 8'h25;
  localparam logic [7:0] ALU_XOR  = 8'h26;
  localparam logic [7:0] ALU_NOR  = 8'h27;
  localparam logic [7:0] ALU_SLL  = 8'h7C;
  localparam logic [7:0] ALU_SRL  = 8'h02;
  localparam logic [7:0] ALU_SRA  = 8'h03;
  localparam logic [7:0] ALU_ADD  = 8'h20;
  localparam logic [7:0] ALU_ADDU = 8'h21;
  localparam logic [7:0] ALU_SUB  = 8'h22;
  localparam logic [7:0] ALU_SUBU = 8'h23;
  localparam logic [7:0] ALU_SLT  = 8'h2A;
  localparam logic [7:0] ALU_SLTU = 8'h2B;

  // Result group selectors
  localparam logic [2:0] ALU_SEL_NONE  = 3'b000;
  localparam logic [2:0] ALU_SEL_LOGIC = 3'b001;
  localparam logic [2:0] ALU_SEL_SHIFT = 3'b010;
  localparam logic [2:0] ALU_SEL_ARITH = 3'b100;

  // Contents of the ID/EX register; data fields are sized to ID_DATA_W,
  // so the top-level DATA_W defaults to that width.
  typedef struct packed {
    logic [ID_DATA_W-1:0] pc;
    logic [7:0]           op;
    logic [2:0]           sel;
    logic [ID_DATA_W-1:0] src1;
    logic [ID_DATA_W-1:0] src2;
    logic [4:0]           wr_addr;
    logic                 wr_en;
    logic                 illegal;
  } id_ex_t;

endpackage

// File: rtl/ins_decode_pipe_fwd_mux.sv
// Operand resolution for one register-file read port: r0 is always zero,
// otherwise the youngest matching forwarding source wins over the RF.
module fwd_mux import ins_decode_pkg::*; #(
  parameter int DATA_W  = ID_DATA_W,
  parameter int NUM_FWD = 2
) (
  input  logic                      en,
  input  logic [4:0]                addr,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]        fwd_en,
  input  logic [5*NUM_FWD-1:0]      fwd_addr,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  output logic [DATA_W-1:0]         data,
  output logic                      hazard
);

  logic found;

  // Priority search from index 0 (youngest) upward; hazard only counts
  // when the port is actually read and the register is not r0.
  always_comb begin
    data   = rf_data;
    hazard = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < NUM_FWD; i++) begin
      if (!found && fwd_en[i] && (fwd_addr[5*i +: 5] == addr)) begin
        found  = 1'b1;
        data   = fwd_data[DATA_W*i +: DATA_W];
        hazard = fwd_is_load[i];
      end
    end
    if (addr == 5'd0) begin
      data   = '0;
      hazard = 1'b0;
    end
    hazard = hazard & en;
  end

endmodule

// File: rtl/ins_decode_pipe.sv
// Registered MIPS32 decode stage with valid/ready on both sides, operand
// forwarding, load-use interlock, flush and a saturating stall counter.
module ins_decode_pipe import ins_decode_pkg::*; #(
  parameter int DATA_W      = ID_DATA_W,
  parameter int NUM_FWD     = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         pc,
  input  logic [31:0]               ins,
  output logic                      rd1_en,
  output logic                      rd2_en,
  output logic [4:0]                addr1,
  output logic [4:0]                addr2,
  input  logic [DATA_W-1:0]         rf_data1,
  input  logic [DATA_W-1:0]         rf_data2,
  input  logic [NUM_FWD-1:0]        fwd_en,
  input  logic [5*NUM_FWD-1:0]      fwd_addr,
  input  logic [DATA_W*NUM_FWD-1:0] fwd_data,
  input  logic [NUM_FWD-1:0]        fwd_is_load,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_pc,
  output logic [7:0]                alu_op,
  output logic [2:0]                alu_sel,
  output logic [DATA_W-1:0]         src_data1,
  output logic [DATA_W-1:0]         src_data2,
  output logic [4:0]                wr_addr,
  output logic                      wr_en,
  output logic                      illegal,
  output logic [STALL_CNT_W-1:0]    stall_cnt
);

  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;

  logic [7:0]        dec_op;
  logic [2:0]        dec_sel;
  logic [4:0]        dec_wr_addr;
  logic              dec_wr_en;
  logic              dec_illegal;
  logic [DATA_W-1:0] alt1, alt2;

  logic [DATA_W-1:0] port1_data, port2_data;
  logic              haz1, haz2, hazard;
  logic              load, transfer;

  id_ex_t                 id_ex_d, id_ex_q;
  logic                   out_valid_d, out_valid_q;
  logic [STALL_CNT_W-1:0] stall_cnt_d, stall_cnt_q;

  assign opcode = ins[31:26];
  assign rs     = ins[25:21];
  assign rt     = ins[20:16];
  assign rd     = ins[15:11];
  assign shamt  = ins[10:6];
  assign funct  = ins[5:0];
  assign imm    = ins[15:0];

  assign addr1 = rs;
  assign addr2 = rt;

  // Instruction decode: anything not matched stays illegal with no write-back.
  always_comb begin
    dec_op      = 8'h00;
    dec_sel     = ALU_SEL_NONE;
    dec_wr_addr = 5'd0;
    dec_wr_en   = 1'b0;
    dec_illegal = 1'b1;
    rd1_en      = 1'b0;
    rd2_en      = 1'b0;
    alt1        = '0;
    alt2        = '0;
    case (opcode)
      OPC_RTYPE: begin
        case (funct)
          FN_AND, FN_OR, FN_XOR, FN_NOR: begin
            if (shamt == 5'd0) begin
              dec_op      = {2'b00, funct};
              dec_sel     = ALU_SEL_LOGIC;
              dec_illegal = 1'b0;
            end
          end
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_SLT, FN_SLTU: begin
            if (shamt == 5'd0) begin
              dec_op      = {2'b00, funct};
              dec_sel     = ALU_SEL_ARITH;
              dec_illegal = 1'b0;
            end
          end
          FN_SLLV, FN_SRLV, FN_SRAV: begin
            if (shamt == 5'd0) begin
              dec_op      = (funct == FN_SLLV) ? ALU_SLL :
                            (funct == FN_SRLV) ? ALU_SRL : ALU_SRA;
              dec_sel     = ALU_SEL_SHIFT;
              dec_illegal = 1'b0;
            end
          end
          FN_SLL, FN_SRL, FN_SRA: begin
            if (rs == 5'd0) begin
              dec_op      = (funct == FN_SLL) ? ALU_SLL :
                            (funct == FN_SRL) ? ALU_SRL : ALU_SRA;
              dec_sel     = ALU_SEL_SHIFT;
              dec_illegal = 1'b0;
            end
          end
          default: ;
        endcase
        if (!dec_illegal) begin
          // Shift-immediate takes shamt in place of rs.
          rd1_en      = !((funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA));
          rd2_en      = 1'b1;
          alt1        = DATA_W'(shamt);
          dec_wr_addr = rd;
          dec_wr_en   = 1'b1;
        end
      end
      OPC_ANDI, OPC_ORI, OPC_XORI: begin
        dec_op      = (opcode == OPC_ANDI) ? ALU_AND :
                      (opcode == OPC_ORI)  ? ALU_OR  : ALU_XOR;
        dec_sel     = ALU_SEL_LOGIC;
        dec_illegal = 1'b0;
        rd1_en      = 1'b1;
        alt2        = DATA_W'(imm);
        dec_wr_addr = rt;
        dec_wr_en   = 1'b1;
      end
      OPC_ADDI, OPC_ADDIU, OPC_SLTI, OPC_SLTIU: begin
        dec_op      = (opcode == OPC_ADDI)  ? ALU_ADD  :
                      (opcode == OPC_ADDIU) ? ALU_ADDU :
                      (opcode == OPC_SLTI)  ? ALU_SLT  : ALU_SLTU;
        dec_sel     = ALU_SEL_ARITH;
        dec_illegal = 1'b0;
        rd1_en      = 1'b1;
        alt2        = DATA_W'($signed(imm));
        dec_wr_addr = rt;
        dec_wr_en   = 1'b1;
      end
      OPC_LUI: begin
        dec_op      = ALU_OR;
        dec_sel     = ALU_SEL_LOGIC;
        dec_illegal = 1'b0;
        alt2        = DATA_W'({imm, 16'h0000});
        dec_wr_addr = rt;
        dec_wr_en   = 1'b1;
      end
      default: ;
    endcase
  end

  fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .en          (rd1_en),
    .addr        (addr1),
    .rf_data     (rf_data1),
    .fwd_en      (fwd_en),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .fwd_is_load (fwd_is_load),
    .data        (port1_data),
    .hazard      (haz1)
  );

  fwd_mux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .en          (rd2_en),
    .addr        (addr2),
    .rf_data     (rf_data2),
    .fwd_en      (fwd_en),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .fwd_is_load (fwd_is_load),
    .data        (port2_data),
    .hazard      (haz2)
  );

  assign hazard   = haz1 | haz2;
  assign load     = out_ready | ~out_valid_q;
  assign in_ready = load & ~hazard & ~flush;
  assign transfer = in_valid & in_ready;

  // Next ID/EX contents: flush beats everything, then transfer, then bubble.
  always_comb begin
    id_ex_d     = id_ex_q;
    out_valid_d = out_valid_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else begin
      if (transfer) begin
        id_ex_d.pc      = pc;
        id_ex_d.op      = dec_op;
        id_ex_d.sel     = dec_sel;
        id_ex_d.src1    = rd1_en ? port1_data : alt1;
        id_ex_d.src2    = rd2_en ? port2_data : alt2;
        id_ex_d.wr_addr = dec_wr_addr;
        id_ex_d.wr_en   = dec_wr_en;
        id_ex_d.illegal = dec_illegal;
        out_valid_d     = 1'b1;
      end else if (load) begin
        out_valid_d = 1'b0;
      end
      if (hazard && in_valid && (stall_cnt_q != STALL_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
    end
  end

  // ID/EX register and stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_ex_q     <= '0;
      out_valid_q <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      id_ex_q     <= id_ex_d;
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = id_ex_q.pc;
  assign alu_op    = id_ex_q.op;
  assign alu_sel   = id_ex_q.sel;
  assign src_data1 = id_ex_q.src1;
  assign src_data2 = id_ex_q.src2;
  assign wr_addr   = id_ex_q.wr_addr;
  assign wr_en     = id_ex_q.wr_en;
  assign illegal   = id_ex_q.illegal;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ins_decode_pipe.sv
// Directed bench for ins_decode_pipe with hand-computed expectations.
module tb_ins_decode_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc;
  logic [31:0] ins;
  logic        rd1_en, rd2_en;
  logic [4:0]  addr1, addr2;
  logic [31:0] rf_data1, rf_data2;
  logic [1:0]  fwd_en;
  logic [9:0]  fwd_addr;
  logic [63:0] fwd_data;
  logic [1:0]  fwd_is_load;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [7:0]  alu_op;
  logic [2:0]  alu_sel;
  logic [31:0] src_data1, src_data2;
  logic [4:0]  wr_addr;
  logic        wr_en;
  logic        illegal;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ins_decode_pipe dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .pc(pc), .ins(ins), .rd1_en(rd1_en), .rd2_en(rd2_en),
    .addr1(addr1), .addr2(addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .fwd_en(fwd_en), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .fwd_is_load(fwd_is_load), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .alu_op(alu_op), .alu_sel(alu_sel),
    .src_data1(src_data1), .src_data2(src_data2), .wr_addr(wr_addr),
    .wr_en(wr_en), .illegal(illegal), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] im);
    return {opc, rs, rt, im};
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; pc = '0; ins = '0;
    rf_data1 = '0; rf_data2 = '0; fwd_en = '0; fwd_addr = '0;
    fwd_data = '0; fwd_is_load = '0; flush = 1'b0; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_src1", src_data1, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    reset = 1'b1;

    // ORI r1,r0,0x8001
    in_valid = 1'b1; pc = 32'h100; ins = enc_i(6'h0D, 5'd0, 5'd1, 16'h8001);
    #1 chk("ori_in_ready", in_ready, 1);
    step();
    chk("ori_valid", out_valid, 1);
    chk("ori_op", alu_op, 8'h25);
    chk("ori_sel", alu_sel, 3'b001);
    chk("ori_src1", src_data1, 0);
    chk("ori_src2", src_data2, 32'h0000_8001);
    chk("ori_wr_addr", wr_addr, 1);
    chk("ori_wr_en", wr_en, 1);
    chk("ori_pc", out_pc, 32'h100);

    // ADDI r2,r1,-1 with both sources forwarding r1; index 0 wins
    pc = 32'h104; ins = enc_i(6'h08, 5'd1, 5'd2, 16'hFFFF);
    fwd_en = 2'b11; fwd_addr = {5'd1, 5'd1}; fwd_data = {32'h20, 32'h10};
    rf_data1 = 32'hDEAD;
    step();
    chk("addi_src1", src_data1, 32'h10);
    chk("addi_src2", src_data2, 32'hFFFF_FFFF);
    chk("addi_op", alu_op, 8'h20);
    chk("addi_sel", alu_sel, 3'b100);
    chk("addi_wr_addr", wr_addr, 2);

    // ADD r3,r2,r2 with a load in flight on source 0 for two cycles
    pc = 32'h108; ins = enc_r(5'd2, 5'd2, 5'd3, 5'd0, 6'h20);
    fwd_en = 2'b01; fwd_addr = {5'd0, 5'd2}; fwd_data = {32'h0, 32'h55};
    fwd_is_load = 2'b01;
    #1 chk("lu_in_ready0", in_ready, 0);
    step();
    chk("lu_bubble0", out_valid, 0);
    chk("lu_cnt1", stall_cnt, 1);
    chk("lu_in_ready1", in_ready, 0);
    step();
    chk("lu_bubble1", out_valid, 0);
    chk("lu_cnt2", stall_cnt, 2);
    fwd_is_load = 2'b00;
    #1 chk("lu_in_ready2", in_ready, 1);
    step();
    chk("lu_accept", out_valid, 1);
    chk("lu_src1", src_data1, 32'h55);
    chk("lu_src2", src_data2, 32'h55);
    chk("lu_cnt_hold", stall_cnt, 2);

    // Backpressure: XOR r6,r7,r8 waits while out_ready=0
    fwd_en = 2'b00; pc = 32'h10C; ins = enc_r(5'd7, 5'd8, 5'd6, 5'd0, 6'h26);
    rf_data1 = 32'hA; rf_data2 = 32'h3; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      step();
      chk("bp_valid", out_valid, 1);
      chk("bp_op_stable", alu_op, 8'h20);
      chk("bp_src1_stable", src_data1, 32'h55);
    end
    out_ready = 1'b1;
    #1 chk("bp_in_ready_rel", in_ready, 1);
    step();
    chk("xor_op", alu_op, 8'h26);
    chk("xor_src1", src_data1, 32'hA);
    chk("xor_src2", src_data2, 32'h3);
    chk("xor_wr_addr", wr_addr, 6);

    // Illegal encoding
    pc = 32'h110; ins = 32'hFC00_0000;
    step();
    chk("ill_valid", out_valid, 1);
    chk("ill_flag", illegal, 1);
    chk("ill_wr_en", wr_en, 0);
    chk("ill_op", alu_op, 0);
    chk("ill_sel", alu_sel, 0);

    // Flush while holding a valid op
    flush = 1'b1; out_ready = 1'b0; pc = 32'h114; ins = 32'h0;
    #1 chk("fl_in_ready", in_ready, 0);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_cnt", stall_cnt, 2);
    flush = 1'b0; out_ready = 1'b1;

    // NOP is a legal SLL to r0
    pc = 32'h118; ins = 32'h0;
    step();
    chk("nop_valid", out_valid, 1);
    chk("nop_illegal", illegal, 0);
    chk("nop_op", alu_op, 8'h7C);

    // Stall again, then reset asynchronously mid-cycle
    pc = 32'h11C; ins = enc_r(5'd2, 5'd2, 5'd3, 5'd0, 6'h20);
    fwd_en = 2'b01; fwd_is_load = 2'b01;
    step();
    chk("st_cnt3", stall_cnt, 3);
    #2 reset = 1'b0;
    #1;
    chk("ar_cnt", stall_cnt, 0);
    chk("ar_pc", out_pc, 0);
    chk("ar_op", alu_op, 0);
    chk("ar_valid", out_valid, 0);

    // Release and issue SLL r4,r5,3
    #1 reset = 1'b1;
    fwd_en = 2'b00; fwd_is_load = 2'b00;
    pc = 32'h120; ins = enc_r(5'd0, 5'd5, 5'd4, 5'd3, 6'h00);
    rf_data1 = 32'hBAD; rf_data2 = 32'h1234;
    #1;
    chk("sll_rd1_en", rd1_en, 0);
    chk("sll_rd2_en", rd2_en, 1);
    chk("sll_addr2", addr2, 5);
    step();
    chk("sll_valid", out_valid, 1);
    chk("sll_src1", src_data1, 3);
    chk("sll_src2", src_data2, 32'h1234);
    chk("sll_op", alu_op, 8'h7C);
    chk("sll_sel", alu_sel, 3'b010);
    chk("sll_wr_addr", wr_addr, 4);

    in_valid = 1'b0;
    step();
    chk("idle_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ins_decode_pipe.md
Name: ins_decode_pipe

Overview:
- Registered, parametrised successor to the combinational decode stage. Decodes one MIPS32 instruction per cycle into ALU operation, ALU selector, source operands and write-back controls, then holds them in an ID/EX output register.
- Adds a valid/ready handshake on both sides and a parametrised N-source forwarding network with priority.
- Adds a load-use interlock that stalls upstream, a flush input, illegal-instruction flagging, arithmetic and sign-extended immediate instructions, and a saturating stall counter.
- Sits between the IF/ID register and the EX stage.

Parameters:
- DATA_W, 32, width of register data, operands and pc.
- NUM_FWD, 2, number of forwarding sources. Index 0 is youngest and has highest priority.
- STALL_CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  pc/ins are valid.
- in_ready  out  1  stage accepts pc/ins this cycle.
- pc  in  DATA_W  instruction address.
- ins  in  32  instruction word.
- rd1_en, rd2_en  out  1  register-file read enables (combinational).
- addr1, addr2  out  5  register-file read addresses: ins[25:21] and ins[20:16] (combinational).
- rf_data1, rf_data2  in  DATA_W  register-file read data, same cycle.
- fwd_en  in  NUM_FWD  forwarding source i will write.
- fwd_addr  in  5*NUM_FWD  destination register, packed.
- fwd_data  in  DATA_W*NUM_FWD  result data, packed.
- fwd_is_load  in  NUM_FWD  source data is not yet available (load in flight).
- flush  in  1  discard the held output and the current input.
- out_valid  out  1  ID/EX register holds a valid op.
- out_ready  in  1  EX consumes the op.
- out_pc  out  DATA_W  pc of the held op.
- alu_op  out  8  operation code.
- alu_sel  out  3  result group selector.
- src_data1, src_data2  out  DATA_W  operands.
- wr_addr  out  5  write-back register.
- wr_en  out  1  write-back enable.
- illegal  out  1  held op is undecodable.
- stall_cnt  out  STALL_CNT_W  load-use stall cycles.

Behaviour:
- Reset: every registered output and stall_cnt are 0.
- Decode table (op / sel):
  - AND 0x24/001, OR 0x25/001, XOR 0x26/001, NOR 0x27/001.
  - SLLV 0x7C/010, SRLV 0x02/010, SRAV 0x03/010.
  - ADD 0x20/100, ADDU 0x21/100, SUB 0x22/100, SUBU 0x23/100, SLT 0x2A/100, SLTU 0x2B/100.
  - R-type requires shamt=0; ports rs and rt enabled; wr_addr=rd.
- Shift-immediate:
  - SLL, SRL, SRA require ins[25:21]=0.
  - src1 = zero-extended shamt; rd1_en=0; src2 = rt.
- I-type (wr_addr=rt, rd2_en=0, src2=imm):
  - ANDI, ORI, XORI: zero-extended immediate.
  - ADDI, ADDIU, SLTI, SLTIU: sign-extended immediate; op 0x20/0x21/0x2A/0x2B, sel 100.
  - LUI: src1=0, src2={imm,16'0}, op OR.
- NOP word 0x00000000 decodes as SLL to r0 and is legal.
- Any other encoding sets illegal=1, wr_en=0, op=0, sel=0.
- Operand resolution for an enabled port, highest priority first:
  - addr==0 gives 0.
  - Lowest-index i with fwd_en[i] and fwd_addr[i]==addr gives fwd_data[i].
  - Otherwise rf_data.
  - A disabled port gives the immediate/shamt value defined above, or 0.
- Load-use hazard: the highest-priority matching source on an enabled port, addr≠0, has fwd_is_load set.
  - in_ready=0.
  - If the output register can load, it loads a bubble (out_valid=0).
  - stall_cnt += 1 per hazard cycle while in_valid, saturating at all-ones.
- Handshake:
  - load = out_ready | ~out_valid.
  - in_ready = load & ~hazard.
  - Transfer when in_valid & in_ready: output register captures the decode and out_valid=1.
  - Output held stable while out_valid & ~out_ready.
  - load & ~transfer sets out_valid=0.
- Flush: highest priority. Next cycle out_valid=0 and in_ready=0 for that cycle. stall_cnt does not increment.
- Latency: one cycle from accepted input to out_valid.
- Reset mid-stall clears all state immediately.

Decomposition:
- Shared package ins_decode_pkg: opcode/funct constants, ALU op codes, ALU_SEL_LOGIC/SHIFT/ARITH, and a packed id_ex_t struct (pc, op, sel, src1, src2, wr_addr, wr_en, illegal).
- Sub-module fwd_mux (one instance per read port): priority match, r0 handling, rf fallback, hazard flag out.

Test Plan:
- ORI r1,r0,0x8001 with out_ready=1 → next cycle out_valid=1, op 0x25, sel 001, src1=0, src2=0x00008001, wr_addr=1, wr_en=1.
- ADDI r2,r1,-1 with fwd0 r1=0x10 and fwd1 r1=0x20 → src1=0x10, src2=0xFFFFFFFF, op 0x20, sel 100.
- ADD r3,r2,r2 with fwd0 r2 is_load for 2 cycles:
  - in_ready=0 for 2 cycles, 2 bubbles, stall_cnt=2.
  - Third cycle accepts using forwarded data.
- out_ready=0 for 3 cycles with in_valid=1 → outputs stable, in_ready=0; first accept only after out_ready=1.
- Instruction 0xFC000000 → illegal=1, wr_en=0. Separately, flush with out_valid=1 → out_valid=0 next cycle.
- Drive reset low during a stall → all outputs and stall_cnt are 0 immediately (asynchronous); after release, SLL r4,r5,3 → src1=3, src2=rf r5.
